// File: rtl/lcd_write_sequencer.sv
// Byte-write sequencer for the 4-bit character LCD bus: splits a byte into two
// nibbles and generates setup / enable / hold timing plus settle gaps.
module lcd_write_sequencer #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned PULSE_CYC      = 12,
  parameter int unsigned HOLD_CYC       = 1,
  parameter int unsigned NIBBLE_GAP_CYC = 50,
  parameter int unsigned WRITE_GAP_CYC  = 2000,
  parameter int unsigned LONG_GAP_CYC   = 82000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  localparam logic [CNT_W-1:0] SetupLast  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PulseLast  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] NibGapLast = CNT_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] WriteLast  = CNT_W'(WRITE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_GAP_CYC - 1);

  typedef enum logic [3:0] {
    StIdle, StSetupHi, StPulseHi, StHoldHi, StGapNib,
    StSetupLo, StPulseLo, StHoldLo, StGapWr
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       wr_byte;
  logic             wr_rs;
  logic             long_gap;
  logic [CNT_W-1:0] gap_last;

  // Clear (0x01) and home (0x02/0x03) need the long settle time.
  assign long_gap = !wr_rs && (wr_byte[7:2] == 6'd0) && (wr_byte != 8'd0);
  assign gap_last = long_gap ? LongLast : WriteLast;
  assign oLCD_RW  = 1'b0;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= StIdle;
      cnt       <= '0;
      wr_byte   <= '0;
      wr_rs     <= 1'b0;
      oReady    <= 1'b1;
      oDone     <= 1'b0;
      oLCD_E    <= 1'b0;
      oLCD_RS   <= 1'b0;
      oLCD_Data <= '0;
    end else begin
      oDone <= 1'b0;
      cnt   <= cnt + 1'b1;
      case (state)
        StIdle: begin
          cnt <= '0;
          if (iValid && oReady) begin
            wr_byte   <= iData;
            wr_rs     <= iRS;
            oLCD_RS   <= iRS;
            oLCD_Data <= iData[7:4];
            oReady    <= 1'b0;
            state     <= StSetupHi;
          end
        end
        StSetupHi: if (cnt == SetupLast) begin
          cnt    <= '0;
          oLCD_E <= 1'b1;
          state  <= StPulseHi;
        end
        StPulseHi: if (cnt == PulseLast) begin
          cnt    <= '0;
          oLCD_E <= 1'b0;
          state  <= StHoldHi;
        end
        StHoldHi: if (cnt == HoldLast) begin
          cnt   <= '0;
          state <= StGapNib;
        end
        StGapNib: if (cnt == NibGapLast) begin
          cnt       <= '0;
          oLCD_RS   <= wr_rs;
          oLCD_Data <= wr_byte[3:0];
          state     <= StSetupLo;
        end
        StSetupLo: if (cnt == SetupLast) begin
          cnt    <= '0;
          oLCD_E <= 1'b1;
          state  <= StPulseLo;
        end
        StPulseLo: if (cnt == PulseLast) begin
          cnt    <= '0;
          oLCD_E <= 1'b0;
          state  <= StHoldLo;
        end
        StHoldLo: if (cnt == HoldLast) begin
          cnt   <= '0;
          state <= StGapWr;
        end
        StGapWr: if (cnt == gap_last) begin
          cnt    <= '0;
          oReady <= 1'b1;
          oDone  <= 1'b1;
          state  <= StIdle;
        end
        default: begin
          cnt    <= '0;
          oReady <= 1'b1;
          oLCD_E <= 1'b0;
          state  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Sequences single-byte writes to the Spartan-3E character LCD over its 4-bit data bus.
- Accepts a byte plus an RS flag through a valid/ready handshake and splits it into two nibbles, high nibble first.
- Generates the setup, enable-pulse and hold timing for each nibble, then enforces the inter-nibble and post-write settle delays.
- Sits between the LCD init/text FSMs and the LCD pins, and replaces ad-hoc per-FSM enable pulsing.

Parameters:
- SETUP_CYC, 2, cycles RS/data are stable before E rises (40 ns at 50 MHz).
- PULSE_CYC, 12, cycles E is high (240 ns).
- HOLD_CYC, 1, cycles RS/data are held after E falls.
- NIBBLE_GAP_CYC, 50, cycles between the high and low nibble (1 us).
- WRITE_GAP_CYC, 2000, settle cycles after a normal write (40 us).
- LONG_GAP_CYC, 82000, settle cycles after a clear/home command (1.64 ms).
- CNT_W, 17, delay counter width; must hold LONG_GAP_CYC-1.
- All *_CYC parameters must be >= 1.

Ports:
- Clock  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-low reset.
- iValid  in  1  write request.
- iRS  in  1  register select: 0 = command, 1 = data.
- iData  in  8  byte to write.
- oReady  out  1  sequencer idle; a request can be accepted.
- oDone  out  1  one-cycle pulse when a write fully completes, including its settle gap.
- oLCD_E  out  1  LCD enable.
- oLCD_RS  out  1  LCD register select.
- oLCD_RW  out  1  LCD read/write; constant 0 (write-only).
- oLCD_Data  out  4  LCD data bus, DB7..DB4.

Behaviour:
- Reset (Reset=0, asynchronous): state goes to IDLE and the counter clears.
  - Outputs: oLCD_E=0, oLCD_RS=0, oLCD_Data=0, oReady=1, oDone=0.
  - Any in-flight write is discarded. E must drop in the same instant Reset asserts, never on a clock edge.
- All outputs are registered. oLCD_RW is tied 0.
- Handshake:
  - A request is accepted on a rising edge where iValid && oReady.
  - iRS and iData are captured into internal registers at that edge. Later input changes are ignored until the next acceptance.
  - oReady=1 only in IDLE.
- States and durations: every timed state lasts exactly its parameter in cycles. The counter clears on entry and the state exits when count == N-1.
  - IDLE: on acceptance -> SETUP_HI.
  - SETUP_HI (SETUP_CYC): oLCD_Data=captured[7:4], oLCD_RS=captured RS, E=0 -> PULSE_HI.
  - PULSE_HI (PULSE_CYC): E=1 -> HOLD_HI.
  - HOLD_HI (HOLD_CYC): E=0, data and RS unchanged -> GAP_NIB.
  - GAP_NIB (NIBBLE_GAP_CYC): E=0 -> SETUP_LO.
  - SETUP_LO, PULSE_LO, HOLD_LO: same as the HI states, with oLCD_Data=captured[3:0] -> GAP_WR.
  - GAP_WR: lasts LONG_GAP_CYC if the captured RS=0 and captured[7:2]==0 and captured!=0 (0x01 clear, 0x02/0x03 home). Otherwise it lasts WRITE_GAP_CYC. -> IDLE.
- oDone=1 for exactly the first IDLE cycle after GAP_WR. That is the same cycle oReady returns to 1.
- Acceptance latency:
  - Acceptance at edge T puts the block in SETUP_HI for the cycle after T.
  - The write spans 2*(SETUP+PULSE+HOLD)+NIBBLE_GAP+gap cycles. With defaults: 2080 normal, 82080 long.
- Data/RS change only on SETUP entry. They never change while E=1 or during HOLD.
- Back-to-back requests: iValid held high is accepted on the oDone cycle. The next SETUP_HI then follows immediately, so there are no idle bubbles beyond that one cycle.
- Illegal or unused state encodings recover to IDLE with E=0.

Test Plan:
- Reset, then iRS=1, iData=0x41 -> Data=4 with E high for 12 cycles; 50-cycle gap; Data=1 with E high for 12 cycles. oDone asserts 2081 cycles after acceptance. RS=1 throughout.
- iRS=0, iData=0x01 -> long gap used. oDone asserts 82081 cycles after acceptance. Repeat with 0x03 -> long; 0x80 and 0x04 -> normal 2081.
- iValid held high with 0x48 then 0x49 -> second acceptance on the oDone cycle. Successive E rising edges of the two writes are 2081 cycles apart.
- iData changed to 0xFF during PULSE_HI -> low nibble still 1 (from 0x41). oLCD_Data is stable across every E-high window and its hold cycle.
- Reset pulled low during PULSE_LO, asynchronously mid-cycle -> oLCD_E falls immediately. After release: oReady=1, oDone never pulses, and no further E pulses occur without a new request.
- Check every cycle: oLCD_RW==0, oReady==(state==IDLE), and oLCD_E=1 only in PULSE_HI/PULSE_LO.
